// File: rtl/encoder8_3_arb.sv
// Sticky 8-request arbiter with a registered highest-priority index encoder.
// Each grant is presented on out/valid until ack, then its pending bit is retired.
module encoder8_3_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [2:0] out,
    output logic       valid,
    output logic [7:0] pending,
    output logic       multi
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] out_nxt;
    logic [7:0] pending_nxt;
    logic [2:0] top_idx;

    // Highest set pending bit; the ascending scan lets the last hit win.
    always_comb begin
        top_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (pending[i]) begin
                top_idx = i[2:0];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        out_nxt     = out;
        pending_nxt = pending;

        case (state)
            IDLE: begin
                if (pending != '0) begin
                    out_nxt   = top_idx;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    pending_nxt[out] = 1'b0;
                    state_nxt        = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Capture is applied after the ack clear so a simultaneous request re-arms the bit.
        if (en) begin
            pending_nxt = pending_nxt | req;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            out     <= '0;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            out     <= out_nxt;
            pending <= pending_nxt;
        end
    end

    assign valid = (state == PRESENT);
    assign multi = ((pending & (pending - 8'd1)) != '0);

endmodule

// File: tb/tb_encoder8_3_arb.sv
// Directed bench for encoder8_3_arb: reset, single grant, priority order,
// hold-through-PRESENT, set-over-clear on ack, and reset mid-grant.
module tb_encoder8_3_arb;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [7:0] req;
    logic       ack;
    logic [2:0] out;
    logic       valid;
    logic [7:0] pending;
    logic       multi;

    int checks = 0;
    int errors = 0;

    encoder8_3_arb dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .req     (req),
        .ack     (ack),
        .out     (out),
        .valid   (valid),
        .pending (pending),
        .multi   (multi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_pend, input logic e_valid,
                           input logic [2:0] e_out, input logic e_multi);
        chk({tag, ".pending"}, pending, e_pend);
        chk({tag, ".valid"}, {7'd0, valid}, {7'd0, e_valid});
        chk({tag, ".out"}, {5'd0, out}, {5'd0, e_out});
        chk({tag, ".multi"}, {7'd0, multi}, {7'd0, e_multi});
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b1; req = 8'hFF; ack = 1'b0;

        // Reset held two edges with all requests asserted
        tick(); tick();
        chk_all("reset", 8'h00, 1'b0, 3'd0, 1'b0);

        // Single request: pending then valid, ack retires it
        reset_n = 1'b1; req = 8'h10;
        tick();             chk_all("single.cap", 8'h10, 1'b0, 3'd0, 1'b0);
        req = 8'h00; tick(); chk_all("single.grant", 8'h10, 1'b1, 3'd4, 1'b0);
        ack = 1'b1;  tick(); chk_all("single.ack", 8'h00, 1'b0, 3'd4, 1'b0);
        ack = 1'b0;

        // Multi-hot 0x25 drained in priority order 5, 2, 0
        req = 8'h25; tick(); chk_all("multi.cap", 8'h25, 1'b0, 3'd4, 1'b1);
        req = 8'h00; tick(); chk_all("multi.g5", 8'h25, 1'b1, 3'd5, 1'b1);
        ack = 1'b1;  tick(); chk_all("multi.a5", 8'h05, 1'b0, 3'd5, 1'b1);
        ack = 1'b0;  tick(); chk_all("multi.g2", 8'h05, 1'b1, 3'd2, 1'b1);
        ack = 1'b1;  tick(); chk_all("multi.a2", 8'h01, 1'b0, 3'd2, 1'b0);
        ack = 1'b0;  tick(); chk_all("multi.g0", 8'h01, 1'b1, 3'd0, 1'b0);
        ack = 1'b1;  tick(); chk_all("multi.a0", 8'h00, 1'b0, 3'd0, 1'b0);
        ack = 1'b0;

        // Higher-priority arrival during PRESENT does not preempt
        req = 8'h02; tick(); chk_all("hold.cap", 8'h02, 1'b0, 3'd0, 1'b0);
        req = 8'h00; tick(); chk_all("hold.g1", 8'h02, 1'b1, 3'd1, 1'b0);
        req = 8'h80; tick(); chk_all("hold.arrive", 8'h82, 1'b1, 3'd1, 1'b1);
        req = 8'h00; tick(); chk_all("hold.still", 8'h82, 1'b1, 3'd1, 1'b1);
        ack = 1'b1;  tick(); chk_all("hold.a1", 8'h80, 1'b0, 3'd1, 1'b0);
        ack = 1'b0;  tick(); chk_all("hold.g7", 8'h80, 1'b1, 3'd7, 1'b0);
        ack = 1'b1;  tick(); chk_all("hold.a7", 8'h00, 1'b0, 3'd7, 1'b0);
        ack = 1'b0;

        // Ack coinciding with a re-request of the same bit: set wins
        req = 8'h08; tick(); chk_all("sw.cap", 8'h08, 1'b0, 3'd7, 1'b0);
        req = 8'h00; tick(); chk_all("sw.g3", 8'h08, 1'b1, 3'd3, 1'b0);
        ack = 1'b1; req = 8'h09; tick(); chk_all("sw.ack_set", 8'h09, 1'b0, 3'd3, 1'b1);
        ack = 1'b0; req = 8'h00; tick(); chk_all("sw.regrant", 8'h09, 1'b1, 3'd3, 1'b1);
        ack = 1'b1; en = 1'b0; req = 8'h08; tick(); chk_all("sw.ack_en0", 8'h01, 1'b0, 3'd3, 1'b0);
        ack = 1'b0; en = 1'b1; req = 8'h00; tick(); chk_all("sw.g0", 8'h01, 1'b1, 3'd0, 1'b0);
        ack = 1'b1;  tick(); chk_all("sw.a0", 8'h00, 1'b0, 3'd0, 1'b0);
        ack = 1'b0;

        // Reset during PRESENT discards the grant without ack
        req = 8'h40; tick(); chk_all("rst.cap", 8'h40, 1'b0, 3'd0, 1'b0);
        req = 8'h00; tick(); chk_all("rst.g6", 8'h40, 1'b1, 3'd6, 1'b0);
        reset_n = 1'b0; req = 8'h21; ack = 1'b1; tick(); chk_all("rst.mid", 8'h00, 1'b0, 3'd0, 1'b0);
        reset_n = 1'b1; req = 8'h00; tick(); chk_all("rst.ack_idle", 8'h00, 1'b0, 3'd0, 1'b0);
        ack = 1'b0; en = 1'b0; req = 8'hFF; tick(); chk_all("rst.en0", 8'h00, 1'b0, 3'd0, 1'b0);
        tick(); chk_all("rst.en0b", 8'h00, 1'b0, 3'd0, 1'b0);

        // Capture resumes once enabled
        en = 1'b1; req = 8'h01; tick(); chk_all("resume.cap", 8'h01, 1'b0, 3'd0, 1'b0);
        req = 8'h00; tick(); chk_all("resume.g0", 8'h01, 1'b1, 3'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder8_3_arb.md
ENCODER8_3_ARB -- requirements
Module: encoder8_3_arb

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-003 SHALL have port: en  input  1  request-capture enable; req is ignored when low.
REQ-004 SHALL have port: req  input  8  request lines, bit i requests index i; multi-hot allowed.
REQ-005 SHALL have port: ack  input  1  consumer acknowledge of the presented index.
REQ-006 SHALL have port: out  output  3  encoded index of the granted request.
REQ-007 SHALL have port: valid  output  1  out holds a granted index awaiting ack.
REQ-008 SHALL have port: pending  output  8  registered sticky request vector.
REQ-009 SHALL have port: multi  output  1  more than one pending bit set (registered view).

Function
REQ-010 SHALL capture requests as pending <= pending | req on each edge where en=1 and reset_n=1; when en=0, pending is unchanged by req.
REQ-011 SHALL implement a 2-state FSM: IDLE (valid=0) and PRESENT (valid=1).
REQ-012 SHALL, in IDLE with pending != 0, load out with the index of the highest set pending bit (bit 7 highest priority, bit 0 lowest) and enter PRESENT on the same edge.
REQ-013 SHALL, in IDLE with pending == 0, remain in IDLE and hold out at its previous value.
REQ-014 SHALL give a latency of 2 edges from req sampled high to valid=1: edge 1 sets pending, edge 2 sets valid/out.
REQ-015 SHALL hold out and valid stable in PRESENT until ack is sampled high; higher-priority requests arriving during PRESENT SHALL NOT change out.
REQ-016 SHALL, on an edge in PRESENT with ack=1, clear pending[out], deassert valid, and return to IDLE.
REQ-017 SHALL, when the ack edge coincides with en=1 and req[out]=1, leave pending[out] set (set wins over clear); other req bits on that edge are captured per REQ-010.
REQ-018 SHALL ignore ack in IDLE (no pending change, no state change).
REQ-019 SHALL re-encode in the IDLE cycle following an ack, giving a minimum of one valid=0 cycle between consecutive grants.
REQ-020 SHALL drive multi = 1 when two or more bits of the pending register are set, combinationally from the register.
REQ-021 SHALL use no combinational path from req or ack to out or valid.
REQ-022 SHALL treat pending as 8 independent bits; no counter wrap or overflow is possible.

Reset
REQ-023 SHALL, on any edge with reset_n=0, set pending=8'h00, out=3'd0, valid=0, and FSM=IDLE, regardless of en, req, ack, or current state.
REQ-024 SHALL discard an in-flight grant on reset mid-PRESENT without requiring ack; requests asserted during reset are not captured.
REQ-025 SHALL resume normal capture on the first edge with reset_n=1.

Verification
REQ-026 SHALL verify: reset_n=0 for 2 edges with req=8'hFF, en=1 -> pending=00, valid=0, out=0, multi=0.
REQ-027 SHALL verify: en=1, req=8'h10 for one edge -> next edge pending=10; following edge valid=1, out=4; ack=1 one edge -> valid=0, pending=00.
REQ-028 SHALL verify: req=8'h25 captured -> multi=1; grants in order out=5, then 2, then 0, each ending on ack, with valid=0 for one cycle between grants and pending 25->05->01->00.
REQ-029 SHALL verify: grant out=1 presented; req=8'h80 arrives -> out stays 1 until ack; then next grant out=7.
REQ-030 SHALL verify: out=3 presented; ack=1 with en=1, req=8'h08 on the same edge -> pending[3] stays 1, valid=0, and out=3 is re-granted next edge. With en=0 -> pending[3]=0.
REQ-031 SHALL verify: valid=1, out=6; reset_n=0 for one edge -> valid=0, pending=00; ack in IDLE and req with en=0 -> no state change.
